// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared ALU opcodes, RV32I major opcodes, FSM encoding and funct3 decode helper
package alu_issue_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SL   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
               f3 == 3'b001 ? ALU_SL :
               f3 == 3'b010 ? ALU_SLT :
               f3 == 3'b011 ? ALU_SLTU :
               f3 == 3'b100 ? ALU_XOR :
               f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == 3'b110 ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/alu_issue_dec.sv
// alu_dec: combinational RV32I R/I/branch decode into ALU opcode and operands
// ports: inst, rs1_val, rs2_val in; op, A, B, is_branch, illegal out
module alu_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [3:0]  op,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        is_branch,
    output logic        illegal
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       is_r, is_i, is_b, shift, f7_ok, alt;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign is_r  = opc == OPC_R;
    assign is_i  = opc == OPC_I;
    assign is_b  = opc == OPC_B;
    assign shift = (is_r || is_i) && (f3 == 3'b001 || f3 == 3'b101);
    assign f7_ok = f7 == 7'b0000000 || f7 == 7'b0100000;
    assign alt   = f7 == 7'b0100000;

    // for non-shift I-type, inst[31:25] is immediate, so funct7 rules only bind shifts
    assign illegal = is_r ? (!f7_ok || (alt && f3 != 3'b000 && f3 != 3'b101)) :
                     is_i ? (shift && (!f7_ok || (alt && f3 == 3'b001))) :
                     is_b ? (f3[2:1] == 2'b01) : 1'b1;

    assign op = illegal ? ALU_AND :
                is_b    ? (f3[2:1] == 2'b00 ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT) :
                f3_op(f3, alt && (is_r || shift));

    assign A = illegal ? 32'd0 : rs1_val;
    assign B = illegal ? 32'd0 :
               shift   ? {27'd0, is_r ? rs2_val[4:0] : inst[24:20]} :
               is_i    ? {{20{inst[31]}}, inst[31:20]} : rs2_val;

    assign is_branch = is_b && !illegal;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: IDLE/EXEC/RESP issue FSM registering ALU operands and capturing the result
// ports: clk, rst_n; in_valid/in_ready, inst, rs1_val, rs2_val request side;
//        alu_A, alu_B, alu_op to the ALU, alu_result, alu_zero back;
//        out_valid/out_ready, out_result, out_taken, out_illegal response side
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_taken,
    output logic        out_illegal
);
    state_t      state, nxt;
    logic [3:0]  d_op;
    logic [31:0] d_a, d_b;
    logic        d_br, d_ill, br, ill, accept, taken;
    logic [2:0]  br_f3;

    alu_dec u_dec (
        .inst      (inst),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .op        (d_op),
        .A         (d_a),
        .B         (d_b),
        .is_branch (d_br),
        .illegal   (d_ill)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;

    always_comb
        nxt = state == S_IDLE ? (in_valid ? S_EXEC : S_IDLE) :
              state == S_EXEC ? S_RESP :
              (out_ready ? S_IDLE : S_RESP);

    always_comb begin
        in_ready  = state == S_IDLE;
        out_valid = state == S_RESP;
    end

    assign accept = in_valid && in_ready;
    // BEQ/BNE use the zero flag, the others the SLT/SLTU bit; funct3[0] inverts
    assign taken  = (br_f3[2:1] == 2'b00 ? alu_zero : alu_result[0]) ^ br_f3[0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op      <= '0;
            br          <= 1'b0;
            ill         <= 1'b0;
            br_f3       <= '0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            alu_A <= d_a;
            alu_B <= d_b;
            alu_op <= d_op;
            br    <= d_br;
            ill   <= d_ill;
            br_f3 <= inst[14:12];
        end else if (state == S_EXEC) begin
            out_result  <= ill ? 32'd0 : alu_result;
            out_taken   <= br && taken;
            out_illegal <= ill;
        end
endmodule
